// File: rtl/id_forwarding_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : id_forwarding_unit
// Brief    : Decode-stage operand forwarding for branches and JALR in a
//            5-stage RV32I pipeline. Chooses register file, WB result or MEM
//            result per source operand, with registered copies of the
//            selects and saturating forward-event counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_forwarding_unit #(
    parameter int                  REG_ADDR_W    = 5,
    parameter int                  OPCODE_W      = 7,
    parameter int                  CNT_W         = 16,
    parameter logic [OPCODE_W-1:0] BRANCH_OPCODE = 7'b1100011,
    parameter logic [OPCODE_W-1:0] JALR_OPCODE   = 7'b1100111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   ID_opcode,
    input  logic                  WB_cntl_RegWrite,
    input  logic                  MEM_cntl_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteRegNum,
    input  logic [REG_ADDR_W-1:0] MEM_WriteRegNum,
    input  logic [REG_ADDR_W-1:0] EX_ReadRegNum1,
    input  logic [REG_ADDR_W-1:0] EX_ReadRegNum2,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic [1:0]            ForwardA_q,
    output logic [1:0]            ForwardB_q,
    output logic [CNT_W-1:0]      fwd_mem_count,
    output logic [CNT_W-1:0]      fwd_wb_count
);

    localparam logic [1:0]       C_SEL_RF  = 2'b00;
    localparam logic [1:0]       C_SEL_WB  = 2'b01;
    localparam logic [1:0]       C_SEL_MEM = 2'b10;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_fwdEnable;
    logic w_memWrites;
    logic w_wbWrites;
    logic w_memHit;
    logic w_wbHit;

    // Only branches and JALR read operands in decode; x0 is never a real producer.
    always_comb begin
        w_fwdEnable = (ID_opcode == BRANCH_OPCODE) || (ID_opcode == JALR_OPCODE);
        w_memWrites = MEM_cntl_RegWrite && (MEM_WriteRegNum != '0);
        w_wbWrites  = WB_cntl_RegWrite  && (WB_WriteRegNum  != '0);
    end

    // Per-operand select; MEM is checked first because it holds the younger write.
    always_comb begin
        ForwardA = C_SEL_RF;
        ForwardB = C_SEL_RF;
        if (w_fwdEnable) begin
            if (w_memWrites && (MEM_WriteRegNum == EX_ReadRegNum1)) begin
                ForwardA = C_SEL_MEM;
            end else if (w_wbWrites && (WB_WriteRegNum == EX_ReadRegNum1)) begin
                ForwardA = C_SEL_WB;
            end
            if (w_memWrites && (MEM_WriteRegNum == EX_ReadRegNum2)) begin
                ForwardB = C_SEL_MEM;
            end else if (w_wbWrites && (WB_WriteRegNum == EX_ReadRegNum2)) begin
                ForwardB = C_SEL_WB;
            end
        end
    end

    // A cycle counts once per source even when both operands use it.
    always_comb begin
        w_memHit = (ForwardA == C_SEL_MEM) || (ForwardB == C_SEL_MEM);
        w_wbHit  = (ForwardA == C_SEL_WB)  || (ForwardB == C_SEL_WB);
    end

    // One-cycle delayed copies of the selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ForwardA_q <= C_SEL_RF;
            ForwardB_q <= C_SEL_RF;
        end else begin
            ForwardA_q <= ForwardA;
            ForwardB_q <= ForwardB;
        end
    end

    // Forward-event counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_mem_count <= '0;
            fwd_wb_count  <= '0;
        end else begin
            if (w_memHit && (fwd_mem_count != C_CNT_MAX)) begin
                fwd_mem_count <= fwd_mem_count + C_CNT_ONE;
            end
            if (w_wbHit && (fwd_wb_count != C_CNT_MAX)) begin
                fwd_wb_count <= fwd_wb_count + C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_forwarding_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_id_forwarding_unit
// Brief    : Directed-vector bench for id_forwarding_unit. Stimulus pushes
//            expected outputs into a queue; a negedge monitor pops and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_forwarding_unit;

    localparam int         C_CNT_W = 16;
    localparam logic [6:0] C_BR    = 7'b1100011;
    localparam logic [6:0] C_JALR  = 7'b1100111;
    localparam logic [6:0] C_ALU   = 7'b0110011;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [6:0]         ID_opcode = '0;
    logic               WB_cntl_RegWrite = 1'b0;
    logic               MEM_cntl_RegWrite = 1'b0;
    logic [4:0]         WB_WriteRegNum = '0;
    logic [4:0]         MEM_WriteRegNum = '0;
    logic [4:0]         EX_ReadRegNum1 = '0;
    logic [4:0]         EX_ReadRegNum2 = '0;
    logic [1:0]         ForwardA;
    logic [1:0]         ForwardB;
    logic [1:0]         ForwardA_q;
    logic [1:0]         ForwardB_q;
    logic [C_CNT_W-1:0] fwd_mem_count;
    logic [C_CNT_W-1:0] fwd_wb_count;

    id_forwarding_unit #(.CNT_W(C_CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .ID_opcode         (ID_opcode),
        .WB_cntl_RegWrite  (WB_cntl_RegWrite),
        .MEM_cntl_RegWrite (MEM_cntl_RegWrite),
        .WB_WriteRegNum    (WB_WriteRegNum),
        .MEM_WriteRegNum   (MEM_WriteRegNum),
        .EX_ReadRegNum1    (EX_ReadRegNum1),
        .EX_ReadRegNum2    (EX_ReadRegNum2),
        .ForwardA          (ForwardA),
        .ForwardB          (ForwardB),
        .ForwardA_q        (ForwardA_q),
        .ForwardB_q        (ForwardB_q),
        .fwd_mem_count     (fwd_mem_count),
        .fwd_wb_count      (fwd_wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic [1:0]         a;
        logic [1:0]         b;
        logic [1:0]         aq;
        logic [1:0]         bq;
        logic [C_CNT_W-1:0] mc;
        logic [C_CNT_W-1:0] wc;
    } exp_t;

    exp_t expQ[$];
    int   nVec  = 0;
    int   nFail = 0;

    // Expected-state tracking: selects of the vector currently applied and counters.
    logic [1:0]         prevA  = 2'b00;
    logic [1:0]         prevB  = 2'b00;
    logic [C_CNT_W-1:0] memCnt = '0;
    logic [C_CNT_W-1:0] wbCnt  = '0;

    task automatic chk(input string vname, input string field, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s.%s: got %0h, expected %0h", vname, field, act, exp);
        end
    endtask

    // Monitor: compare everything the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk(e.name, "ForwardA",      int'(ForwardA),      int'(e.a));
            chk(e.name, "ForwardB",      int'(ForwardB),      int'(e.b));
            chk(e.name, "ForwardA_q",    int'(ForwardA_q),    int'(e.aq));
            chk(e.name, "ForwardB_q",    int'(ForwardB_q),    int'(e.bq));
            chk(e.name, "fwd_mem_count", int'(fwd_mem_count), int'(e.mc));
            chk(e.name, "fwd_wb_count",  int'(fwd_wb_count),  int'(e.wc));
        end
    end

    // Account for one rising edge in the expected state.
    task automatic modelEdge();
        if ((prevA == 2'b10 || prevB == 2'b10) && memCnt != '1) memCnt = memCnt + 1'b1;
        if ((prevA == 2'b01 || prevB == 2'b01) && wbCnt  != '1) wbCnt  = wbCnt  + 1'b1;
    endtask

    task automatic applyVec(input string vname, input logic [6:0] opc,
                            input logic wbRw, input logic [4:0] wbRd,
                            input logic memRw, input logic [4:0] memRd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [1:0] expA, input logic [1:0] expB);
        exp_t e;
        @(posedge clk);
        modelEdge();
        e.name = vname;
        e.aq   = prevA;
        e.bq   = prevB;
        #1;
        ID_opcode         = opc;
        WB_cntl_RegWrite  = wbRw;
        WB_WriteRegNum    = wbRd;
        MEM_cntl_RegWrite = memRw;
        MEM_WriteRegNum   = memRd;
        EX_ReadRegNum1    = rs1;
        EX_ReadRegNum2    = rs2;
        e.a  = expA;
        e.b  = expB;
        e.mc = memCnt;
        e.wc = wbCnt;
        expQ.push_back(e);
        prevA = expA;
        prevB = expB;
    endtask

    // Raise reset mid-cycle with inputs held; registers must clear before the next edge.
    task automatic midReset(input string vname);
        exp_t e;
        @(posedge clk);
        #2;
        rst    = 1'b1;
        memCnt = '0;
        wbCnt  = '0;
        e.name = vname;
        e.a    = prevA;
        e.b    = prevB;
        e.aq   = 2'b00;
        e.bq   = 2'b00;
        e.mc   = '0;
        e.wc   = '0;
        expQ.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        // Reset state with forwarding disabled.
        @(posedge clk);
        #1;
        e.name = "reset";
        e.a = 2'b00; e.b = 2'b00; e.aq = 2'b00; e.bq = 2'b00; e.mc = '0; e.wc = '0;
        expQ.push_back(e);
        @(negedge clk);
        #1;
        rst = 1'b0;

        //        name          opc     wbRw wbRd memRw memRd rs1 rs2  A      B
        applyVec("no_write",    C_BR,   0, 0,  0, 0,  1, 2, 2'b00, 2'b00);
        applyVec("wb_rs1",      C_BR,   1, 1,  0, 0,  1, 2, 2'b01, 2'b00);
        applyVec("mem_rs1",     C_BR,   0, 0,  1, 1,  1, 2, 2'b10, 2'b00);
        applyVec("mem_rs2",     C_BR,   0, 0,  1, 2,  1, 2, 2'b00, 2'b10);
        applyVec("wb_rs2",      C_BR,   1, 2,  0, 0,  1, 2, 2'b00, 2'b01);
        applyVec("prio_rs1",    C_BR,   1, 1,  1, 1,  1, 2, 2'b10, 2'b00);
        applyVec("prio_rs2",    C_BR,   1, 2,  1, 2,  1, 2, 2'b00, 2'b10);
        applyVec("x0_never",    C_BR,   1, 0,  1, 0,  0, 2, 2'b00, 2'b00);
        applyVec("alu_opcode",  C_ALU,  0, 0,  1, 1,  1, 2, 2'b00, 2'b00);
        applyVec("jalr_split",  C_JALR, 1, 2,  1, 1,  1, 2, 2'b10, 2'b01);
        applyVec("wb_both",     C_JALR, 1, 3,  0, 0,  3, 3, 2'b01, 2'b01);
        applyVec("rw_gated",    C_BR,   0, 1,  0, 1,  1, 1, 2'b00, 2'b00);
        applyVec("mem_both",    C_JALR, 1, 5,  1, 5,  5, 5, 2'b10, 2'b10);
        applyVec("wb_again",    C_BR,   1, 7,  0, 0,  7, 4, 2'b01, 2'b00);
        midReset("async_rst");
        applyVec("after_rst",   C_BR,   0, 0,  1, 1,  1, 1, 2'b10, 2'b10);
        applyVec("hold_mem",    C_BR,   0, 0,  1, 1,  1, 1, 2'b10, 2'b10);

        // Hold the MEM match long enough to pass the counter's full range.
        for (int i = 0; i < (1 << C_CNT_W) + 2; i++) begin
            @(posedge clk);
            modelEdge();
        end
        applyVec("saturate",    C_BR,   0, 0,  1, 1,  1, 1, 2'b10, 2'b10);
        applyVec("sat_hold",    C_BR,   1, 2,  0, 0,  3, 2, 2'b00, 2'b01);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (expQ.size() != 0) begin
            nVec++;
            nFail++;
            $display("FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_forwarding_unit.md
Name: id_forwarding_unit

Overview:
- Decode-stage (ID) forwarding unit for the RV32I 5-stage pipeline.
- Resolves operand hazards for instructions that consume registers in ID: conditional branches and JALR.
- Selects, per source operand, whether the value comes from the register file, the WB-stage result or the MEM-stage result.
- Provides combinational selects for the current cycle, registered copies of the selects, and event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register-number width.
- OPCODE_W, 7, opcode width.
- CNT_W, 16, width of each forward-event counter.
- BRANCH_OPCODE, 7'b1100011, opcode of conditional branches.
- JALR_OPCODE, 7'b1100111, opcode of JALR.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- ID_opcode  in  OPCODE_W  opcode of the instruction in ID.
- WB_cntl_RegWrite  in  1  WB-stage instruction writes the register file.
- MEM_cntl_RegWrite  in  1  MEM-stage instruction writes the register file.
- WB_WriteRegNum  in  REG_ADDR_W  destination register of the WB-stage instruction.
- MEM_WriteRegNum  in  REG_ADDR_W  destination register of the MEM-stage instruction.
- EX_ReadRegNum1  in  REG_ADDR_W  rs1 of the instruction being resolved.
- EX_ReadRegNum2  in  REG_ADDR_W  rs2 of the instruction being resolved.
- ForwardA  out  2  rs1 select (combinational).
- ForwardB  out  2  rs2 select (combinational).
- ForwardA_q  out  2  ForwardA registered on clk.
- ForwardB_q  out  2  ForwardB registered on clk.
- fwd_mem_count  out  CNT_W  count of cycles in which any operand selected the MEM source.
- fwd_wb_count  out  CNT_W  count of cycles in which any operand selected the WB source.

Behaviour:
- Select encoding:
  - 2'b00 = register file.
  - 2'b01 = WB result.
  - 2'b10 = MEM result.
  - 2'b11 is never driven.
- Forwarding is enabled only when ID_opcode equals BRANCH_OPCODE or JALR_OPCODE. For every other opcode, ForwardA = ForwardB = 00.
- ForwardA is purely combinational, zero latency, evaluated in priority order:
  1. MEM_cntl_RegWrite=1, MEM_WriteRegNum!=0 and MEM_WriteRegNum==EX_ReadRegNum1 -> 10.
  2. Otherwise, WB_cntl_RegWrite=1, WB_WriteRegNum!=0 and WB_WriteRegNum==EX_ReadRegNum1 -> 01.
  3. Otherwise -> 00.
- ForwardB uses identical rules with EX_ReadRegNum2.
- MEM has priority over WB when both match, because MEM holds the younger write.
- Register x0 is never forwarded, even when RegWrite=1 and the register numbers match.
- A and B are evaluated independently. Both may forward, from the same or different stages.
- ForwardA and ForwardB do not depend on clk or rst.
- Registered copies: on each rising clk edge, ForwardA_q<=ForwardA and ForwardB_q<=ForwardB (one-cycle latency).
- Counters, per rising edge:
  - fwd_mem_count increments by 1 if ForwardA==10 or ForwardB==10. Increment is at most 1 per cycle.
  - fwd_wb_count increments by 1 if ForwardA==01 or ForwardB==01.
  - Both counters saturate at all-ones and never wrap.
- Reset: while rst=1, asynchronously ForwardA_q=00, ForwardB_q=00, fwd_mem_count=0, fwd_wb_count=0. Reset asserted mid-operation clears these immediately; combinational outputs are unaffected.
- No X propagation from the registered outputs after reset. Inputs are required to be known whenever forwarding is enabled.

Test Plan:
- Opcode 1100011, rs1=1, rs2=2, both RegWrite=0 -> ForwardA=00, ForwardB=00.
- Opcode 1100011, WB RegWrite=1, WB rd=1, MEM RegWrite=0 -> ForwardA=01, ForwardB=00; next edge ForwardA_q=01; fwd_wb_count increments by 1.
- MEM RegWrite=1, MEM rd=1, WB RegWrite=0 -> ForwardA=10. Same with MEM rd=2 -> ForwardA=00, ForwardB=10.
- WB rd=2, WB RegWrite=1, MEM RegWrite=0 -> ForwardA=00, ForwardB=01.
- Both RegWrite=1 and both rd=1 -> ForwardA=10 (MEM priority). Both rd=2 -> ForwardB=10. Both rd=0 with rs1=0 -> ForwardA=00.
- Opcode 0110011 with a matching MEM rd -> selects 00. Assert rst asynchronously mid-run -> ForwardA_q, ForwardB_q and both counters go to 0 immediately. Hold the MEM match for 2^CNT_W+2 cycles -> fwd_mem_count saturates at all-ones.
